exception_ctrl: RTL and testbench
=================================

Name: exception_ctrl

Overview:
- Exception sequencer directly upstream of the PCSource 4x1 mux.
- Detects invalid-opcode, overflow and divide-by-zero events and saves EPC.
- Fetches the 8-bit handler vector byte from memory, sign-extends it, and drives the mux's EPC and SE8_32 inputs.
- Also supplies the override select/write for exception entry and for return-from-exception (rte).

Parameters:
- MEM_LAT, 2, memory read latency in cycles (>=1); number of MEM_WAIT cycles.
- VEC_BASE, 32'd253, vector byte address for cause 0; cause n reads VEC_BASE+n.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- pc_in  in  32  current PC (already PC+4 of faulting instruction).
- exc_opcode  in  1  invalid-opcode event, level sampled in IDLE.
- exc_overflow  in  1  ALU overflow event.
- exc_divzero  in  1  divide-by-zero event.
- rte  in  1  return-from-exception decoded.
- mem_data_i  in  8  vector byte returned by memory.
- mem_rd_o  out  1  memory read strobe.
- mem_addr_o  out  32  memory read address.
- epc_o  out  32  saved EPC; feeds mux input 01.
- vector_o  out  32  sign-extended vector; feeds mux input 11.
- cause_o  out  2  00 opcode, 01 overflow, 10 divzero.
- pc_source_o  out  2  mux select, valid while override_o=1.
- pc_write_o  out  1  PC load enable, one-cycle pulse.
- override_o  out  1  this block owns PCSource/PCWrite this cycle.
- busy_o  out  1  main controller must stall.

Behaviour:
- States: IDLE, MEM_REQ, MEM_WAIT, LOAD_PC, RET.
- Reset (reset=0 at edge) forces the following, from any state including mid-sequence:
  - state goes to IDLE.
  - epc_o, vector_o, mem_addr_o and cause_o go to 0.
  - The wait counter goes to 0.
  - No pc_write_o pulse is issued.
- All outputs are Moore outputs decoded from registered state; registers are reset-clean.
- IDLE, any exception input high at the edge:
  - epc_o <= pc_in - 32'd4, modulo 2^32 (pc_in=0 gives 32'hFFFFFFFC).
  - cause_o is latched with priority opcode > overflow > divzero.
  - state <= MEM_REQ.
- IDLE, rte high with no exception: state <= RET. An exception and rte together: exception wins and rte is dropped.
- MEM_REQ, 1 cycle:
  - mem_rd_o=1 and mem_addr_o=VEC_BASE+cause_o; busy_o=1.
  - Counter is loaded to MEM_LAT-1; state <= MEM_WAIT.
- MEM_WAIT, MEM_LAT cycles:
  - mem_addr_o is held, mem_rd_o=0, busy_o=1.
  - On the last cycle (counter=0), vector_o <= {{24{mem_data_i[7]}}, mem_data_i} and state <= LOAD_PC.
- LOAD_PC, 1 cycle: pc_source_o=2'b11, pc_write_o=1, override_o=1, busy_o=1; state <= IDLE.
- RET, 1 cycle:
  - pc_source_o=2'b01, pc_write_o=1, override_o=1, busy_o=1; state <= IDLE.
  - epc_o is unchanged.
- All other cycles: pc_source_o=2'b00, pc_write_o=0, override_o=0.
- busy_o=0 only in IDLE.
- Latency: detection edge to the pc_write_o cycle is MEM_LAT+2 cycles; rte costs 1 cycle.
- Exception and rte inputs are ignored in every state except IDLE (no queuing).
- A new exception after return to IDLE overwrites epc_o and cause_o (no nesting).
- vector_o and epc_o hold their values until overwritten or reset.

Test Plan:
- Reset: assert reset=0 for 2 cycles mid-MEM_WAIT -> next cycle state IDLE, all outputs 0, no pc_write_o pulse.
- Overflow entry: pc_in=32'h0000_0104, exc_overflow=1 in IDLE, mem_data_i=8'h40 -> the following, then busy_o=0:
  - epc_o=32'h100, cause_o=01, mem_addr_o=254.
  - 4 cycles after detection: pc_source_o=11, pc_write_o=1 for 1 cycle, vector_o=32'h40.
- Priority and sign extension: exc_opcode=exc_divzero=1, mem_data_i=8'hF0 -> cause_o=00, mem_addr_o=253, vector_o=32'hFFFFFFF0.
- rte: rte=1 in IDLE with epc_o=32'h100 -> next cycle pc_source_o=01, pc_write_o=1, override_o=1, then IDLE.
- Simultaneous and ignored events:
  - rte and exc_divzero high together -> exception sequence taken, RET never entered.
  - exc_overflow pulsed during MEM_WAIT -> ignored; epc_o unchanged.
- Wrap and latency: pc_in=0 with exc_opcode -> epc_o=32'hFFFFFFFC. With MEM_LAT=5, pc_write_o occurs exactly 7 cycles after the detection edge.

Source files
------------

// File: rtl/exception_ctrl.sv
// exception_ctrl: exception sequencer feeding the PCSource 4x1 mux.
//   Detects invalid-opcode / overflow / divide-by-zero in IDLE, saves EPC,
//   fetches the 8-bit handler vector byte, sign-extends it and loads PC
//   through mux input 11; rte loads PC from EPC through mux input 01.
// Ports:
//   clk, reset (sync, active-low)
//   pc_in         current PC (PC+4 of the faulting instruction)
//   exc_opcode, exc_overflow, exc_divzero, rte  event inputs, sampled in IDLE only
//   mem_data_i    vector byte from memory; mem_rd_o / mem_addr_o read request
//   epc_o, vector_o  mux data inputs 01 / 11
//   cause_o       00 opcode, 01 overflow, 10 divzero
//   pc_source_o, pc_write_o, override_o  PC control while this block owns it
//   busy_o        main controller stall
module exception_ctrl #(
  parameter int          MEM_LAT  = 2,
  parameter logic [31:0] VEC_BASE = 32'd253
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_divzero,
  input  logic        rte,
  input  logic [7:0]  mem_data_i,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] epc_o,
  output logic [31:0] vector_o,
  output logic [1:0]  cause_o,
  output logic [1:0]  pc_source_o,
  output logic        pc_write_o,
  output logic        override_o,
  output logic        busy_o
);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, LOAD_PC, RET} stateT;
  stateT state, nextState;
  logic [CW-1:0] waitCnt;
  logic anyExc, lastWait;
  logic [1:0] newCause;
  assign anyExc   = exc_opcode | exc_overflow | exc_divzero;
  assign newCause = exc_opcode ? 2'b00 : exc_overflow ? 2'b01 : 2'b10;
  assign lastWait = waitCnt == '0;
  always_ff @(posedge clk)
    state <= !reset ? IDLE : nextState;
  // An exception outranks a simultaneous rte; the rte is simply dropped.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:     nextState = anyExc ? MEM_REQ : rte ? RET : IDLE;
      MEM_REQ:  nextState = MEM_WAIT;
      MEM_WAIT: nextState = lastWait ? LOAD_PC : MEM_WAIT;
      default:  nextState = IDLE;
    endcase
  end
  always_comb begin
    mem_rd_o    = state == MEM_REQ;
    busy_o      = state != IDLE;
    pc_write_o  = (state == LOAD_PC) | (state == RET);
    override_o  = pc_write_o;
    pc_source_o = state == LOAD_PC ? 2'b11 : state == RET ? 2'b01 : 2'b00;
  end
  // The vector address is registered at detection so it is already stable
  // during the MEM_REQ cycle and held through MEM_WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      epc_o      <= '0;
      vector_o   <= '0;
      mem_addr_o <= '0;
      cause_o    <= '0;
      waitCnt    <= '0;
    end else begin
      if (state == IDLE && anyExc) begin
        epc_o      <= pc_in - 32'd4;
        cause_o    <= newCause;
        mem_addr_o <= VEC_BASE + {30'd0, newCause};
      end
      if (state == MEM_REQ)
        waitCnt <= CW'(MEM_LAT - 1);
      else if (state == MEM_WAIT && !lastWait)
        waitCnt <= waitCnt - CW'(1);
      if (state == MEM_WAIT && lastWait)
        vector_o <= {{24{mem_data_i[7]}}, mem_data_i};
    end
  end
endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: directed self-checking bench for exception_ctrl (MEM_LAT=2 and MEM_LAT=5).
module tb_exception_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] pcIn;
  logic excOpcode, excOverflow, excDivzero, rte;
  logic [7:0] memData;
  logic memRd, pcWrite, override, busy;
  logic [31:0] memAddr, epc, vector;
  logic [1:0] cause, pcSource;
  logic memRd5, pcWrite5, override5, busy5;
  logic [31:0] memAddr5, epc5, vector5;
  logic [1:0] cause5, pcSource5;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exception_ctrl #(.MEM_LAT(2)) dut (
    .clk(clk), .reset(reset), .pc_in(pcIn), .exc_opcode(excOpcode),
    .exc_overflow(excOverflow), .exc_divzero(excDivzero), .rte(rte),
    .mem_data_i(memData), .mem_rd_o(memRd), .mem_addr_o(memAddr),
    .epc_o(epc), .vector_o(vector), .cause_o(cause), .pc_source_o(pcSource),
    .pc_write_o(pcWrite), .override_o(override), .busy_o(busy)
  );

  exception_ctrl #(.MEM_LAT(5)) dut5 (
    .clk(clk), .reset(reset), .pc_in(pcIn), .exc_opcode(excOpcode),
    .exc_overflow(excOverflow), .exc_divzero(excDivzero), .rte(rte),
    .mem_data_i(memData), .mem_rd_o(memRd5), .mem_addr_o(memAddr5),
    .epc_o(epc5), .vector_o(vector5), .cause_o(cause5), .pc_source_o(pcSource5),
    .pc_write_o(pcWrite5), .override_o(override5), .busy_o(busy5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearEvents();
    excOpcode = 0; excOverflow = 0; excDivzero = 0; rte = 0;
  endtask

  task automatic test_reset();
    reset = 0; pcIn = 32'h204; memData = 8'h55; clearEvents();
    tick(); tick();
    checks++;
    if ({busy, pcWrite, override, memRd, pcSource} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, pcWrite, override, memRd, pcSource});
    end
    checks++;
    if ({epc, vector, memAddr, cause} !== 98'd0) begin
      errors++; $display("FAIL reset_data: got epc=%h vec=%h addr=%h cause=%b expected all 0", epc, vector, memAddr, cause);
    end
    reset = 1; excOverflow = 1;
    tick();
    excOverflow = 0;
    tick();
    checks++;
    if ({busy, memRd, memAddr} !== {2'b10, 32'd254}) begin
      errors++; $display("FAIL reset_pre_wait: got busy=%b rd=%b addr=%0d expected busy=1 rd=0 addr=254", busy, memRd, memAddr);
    end
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (pcWrite !== 1'b0) begin
        errors++; $display("FAIL reset_no_pulse[%0d]: got pc_write=%b expected 0", i, pcWrite);
      end
    end
    checks++;
    if ({busy, override, memRd, pcSource, epc, vector, memAddr, cause} !== 103'd0) begin
      errors++; $display("FAIL reset_mid_wait: got busy=%b epc=%h vec=%h addr=%h cause=%b expected all 0", busy, epc, vector, memAddr, cause);
    end
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({busy, pcWrite} !== 2'b00) begin
        errors++; $display("FAIL reset_after[%0d]: got busy=%b pc_write=%b expected 0 0", i, busy, pcWrite);
      end
    end
  endtask

  task automatic test_overflow();
    pcIn = 32'h0000_0104; memData = 8'h40; excOverflow = 1;
    tick();
    excOverflow = 0;
    checks++;
    if ({epc, cause, memAddr, memRd, busy, pcWrite} !== {32'h100, 2'b01, 32'd254, 3'b110}) begin
      errors++; $display("FAIL ovf_req: got epc=%h cause=%b addr=%0d rd=%b busy=%b pw=%b expected 100 01 254 1 1 0", epc, cause, memAddr, memRd, busy, pcWrite);
    end
    for (int k = 2; k <= 3; k++) begin
      tick();
      checks++;
      if ({memRd, memAddr, busy, pcWrite, override} !== {1'b0, 32'd254, 3'b100}) begin
        errors++; $display("FAIL ovf_wait[%0d]: got rd=%b addr=%0d busy=%b pw=%b ov=%b expected 0 254 1 0 0", k, memRd, memAddr, busy, pcWrite, override);
      end
    end
    tick();
    checks++;
    if ({pcSource, pcWrite, override, busy, vector} !== {5'b11111, 32'h40}) begin
      errors++; $display("FAIL ovf_load: got src=%b pw=%b ov=%b busy=%b vec=%h expected 11 1 1 1 00000040", pcSource, pcWrite, override, busy, vector);
    end
    tick();
    checks++;
    if ({pcSource, pcWrite, override, busy, vector, epc} !== {5'b0, 32'h40, 32'h100}) begin
      errors++; $display("FAIL ovf_done: got src=%b pw=%b ov=%b busy=%b vec=%h epc=%h expected 00 0 0 0 40 100", pcSource, pcWrite, override, busy, vector, epc);
    end
  endtask

  task automatic test_rte();
    rte = 1;
    tick();
    rte = 0;
    checks++;
    if ({pcSource, pcWrite, override, busy, memRd, epc} !== {6'b011110, 32'h100}) begin
      errors++; $display("FAIL rte_ret: got src=%b pw=%b ov=%b busy=%b rd=%b epc=%h expected 01 1 1 1 0 100", pcSource, pcWrite, override, busy, memRd, epc);
    end
    tick();
    checks++;
    if ({pcSource, pcWrite, override, busy, epc} !== {5'b0, 32'h100}) begin
      errors++; $display("FAIL rte_idle: got src=%b pw=%b ov=%b busy=%b epc=%h expected 00 0 0 0 100", pcSource, pcWrite, override, busy, epc);
    end
  endtask

  task automatic test_priority();
    pcIn = 32'h300; memData = 8'hF0; excOpcode = 1; excDivzero = 1;
    tick();
    clearEvents();
    checks++;
    if ({cause, memAddr, epc} !== {2'b00, 32'd253, 32'h2FC}) begin
      errors++; $display("FAIL prio_cause: got cause=%b addr=%0d epc=%h expected 00 253 2fc", cause, memAddr, epc);
    end
    tick(); tick(); tick();
    checks++;
    if ({pcSource, pcWrite, vector} !== {3'b111, 32'hFFFF_FFF0}) begin
      errors++; $display("FAIL prio_sext: got src=%b pw=%b vec=%h expected 11 1 fffffff0", pcSource, pcWrite, vector);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    pcIn = 32'h50; memData = 8'h7F; rte = 1; excDivzero = 1;
    tick();
    clearEvents();
    checks++;
    if ({cause, memAddr, memRd, pcSource, pcWrite, epc} !== {2'b10, 32'd255, 4'b1000, 32'h4C}) begin
      errors++; $display("FAIL simul_entry: got cause=%b addr=%0d rd=%b src=%b pw=%b epc=%h expected 10 255 1 00 0 4c", cause, memAddr, memRd, pcSource, pcWrite, epc);
    end
    tick(); tick(); tick();
    checks++;
    if ({pcSource, pcWrite, vector} !== {3'b111, 32'h7F}) begin
      errors++; $display("FAIL simul_load: got src=%b pw=%b vec=%h expected 11 1 0000007f", pcSource, pcWrite, vector);
    end
    tick();
    checks++;
    if ({busy, pcWrite, pcSource} !== 4'b0) begin
      errors++; $display("FAIL simul_no_ret: got busy=%b pw=%b src=%b expected 0 0 00", busy, pcWrite, pcSource);
    end
  endtask

  task automatic test_ignored();
    pcIn = 32'h800; memData = 8'h01; excOverflow = 1;
    tick();
    excOverflow = 0;
    tick();
    pcIn = 32'h900; excOverflow = 1; rte = 1;
    tick();
    clearEvents();
    checks++;
    if ({epc, cause, busy, pcWrite} !== {32'h7FC, 2'b01, 2'b10}) begin
      errors++; $display("FAIL ignore_wait: got epc=%h cause=%b busy=%b pw=%b expected 7fc 01 1 0", epc, cause, busy, pcWrite);
    end
    tick();
    checks++;
    if ({pcSource, pcWrite, vector} !== {3'b111, 32'h1}) begin
      errors++; $display("FAIL ignore_load: got src=%b pw=%b vec=%h expected 11 1 00000001", pcSource, pcWrite, vector);
    end
    tick(); tick();
    checks++;
    if ({busy, pcWrite, epc} !== {2'b00, 32'h7FC}) begin
      errors++; $display("FAIL ignore_no_queue: got busy=%b pw=%b epc=%h expected 0 0 7fc", busy, pcWrite, epc);
    end
  endtask

  task automatic test_wrap_latency();
    for (int i = 0; i < 10; i++) tick();
    pcIn = 32'h0; memData = 8'h80; excOpcode = 1;
    tick();
    excOpcode = 0;
    checks++;
    if ({epc, epc5, cause5, memAddr5} !== {32'hFFFF_FFFC, 32'hFFFF_FFFC, 2'b00, 32'd253}) begin
      errors++; $display("FAIL wrap_epc: got epc=%h epc5=%h cause5=%b addr5=%0d expected fffffffc fffffffc 00 253", epc, epc5, cause5, memAddr5);
    end
    for (int k = 2; k <= 8; k++) begin
      tick();
      checks++;
      if (pcWrite5 !== (k == 7)) begin
        errors++; $display("FAIL lat5_cycle%0d: got pc_write=%b expected %b", k, pcWrite5, k == 7);
      end
      if (k == 7) begin
        checks++;
        if ({pcSource5, vector5} !== {2'b11, 32'hFFFF_FF80}) begin
          errors++; $display("FAIL lat5_load: got src=%b vec=%h expected 11 ffffff80", pcSource5, vector5);
        end
      end
    end
    checks++;
    if (busy5 !== 1'b0) begin
      errors++; $display("FAIL lat5_idle: got busy=%b expected 0", busy5);
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_rte();
    test_priority();
    test_simultaneous();
    test_ignored();
    test_wrap_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
